// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache controller.
// Address split: tag [31:6], index [5:4], word offset [3:2].
package dcache_pkg;
  localparam int LINES     = 4;
  localparam int LINE_BITS = 128;
  localparam int ADDR_W    = 32;
  localparam int OFFSET_W  = 2;
  localparam int IDX_W     = 2;
  localparam int TAG_W     = 26;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WB,
    FILL
  } state_e;

  typedef logic [ADDR_W-1:0]    word_t;
  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [OFFSET_W-1:0]  off_t;
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage with combinational reads,
// a drain word-write port and a fill line-write port.
module dcache_array
  import dcache_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  idx_t  rd_idx,
  output logic  rd_valid,
  output logic  rd_dirty,
  output tag_t  rd_tag,
  output line_t rd_line,
  input  idx_t  chk_idx,
  output logic  chk_valid,
  output tag_t  chk_tag,
  input  logic  ww_en,
  input  idx_t  ww_idx,
  input  off_t  ww_off,
  input  word_t ww_data,
  input  logic  lw_en,
  input  idx_t  lw_idx,
  input  tag_t  lw_tag,
  input  line_t lw_line
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  tag_t             tag_q  [LINES];
  line_t            data_q [LINES];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_dirty  = dirty_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_line   = data_q[rd_idx];
  assign chk_valid = valid_q[chk_idx];
  assign chk_tag   = tag_q[chk_idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (lw_en) begin
      valid_d[lw_idx] = 1'b1;
      dirty_d[lw_idx] = 1'b0;
    end else if (ww_en) begin
      dirty_d[ww_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Contents are meaningless until valid is set, so no reset here.
  always_ff @(posedge clk) begin
    if (lw_en) begin
      tag_q[lw_idx]  <= lw_tag;
      data_q[lw_idx] <= lw_line;
    end else if (ww_en) begin
      data_q[ww_idx][{ww_off, 5'd0} +: 32] <= ww_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 D-cache controller:
// M-stage lookups, store-buffer drains, memory writeback/fill.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         is_load,
  input  logic         is_store,
  input  logic [31:0]  address,
  input  logic         hit_storeBuffer,
  output logic         cache_hit,
  output logic [31:0]  data_read,
  output logic         stall,
  output logic         cache_ready_to_catch,
  input  logic         sending_data_to_cache,
  input  logic [63:0]  data_to_cache,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  state_e state_q, state_d;
  logic   dwell_q, dwell_d;
  word_t  miss_q, miss_d;

  tag_t  req_tag;
  idx_t  req_idx;
  off_t  req_off;
  idx_t  rd_idx;
  logic  rd_valid, rd_dirty;
  tag_t  rd_tag;
  line_t rd_line;
  word_t rd_word;
  word_t sb_addr, sb_data;
  logic  chk_valid;
  tag_t  chk_tag;
  logic  drain_ok, fwd, miss;
  logic  lw_en, stall_c, ready_c;
  logic  unused_bits;

  assign req_tag = address[31:6];
  assign req_idx = address[5:4];
  assign req_off = address[3:2];
  assign sb_addr = data_to_cache[63:32];
  assign sb_data = data_to_cache[31:0];
  assign unused_bits = ^{address[1:0], sb_addr[1:0]};

  // Outside IDLE the array is steered to the line being replaced.
  assign rd_idx  = (state_q == IDLE) ? req_idx : miss_q[5:4];
  assign rd_word = rd_line[{req_off, 5'd0} +: 32];

  assign cache_hit = rd_valid && (rd_tag == req_tag);

  assign drain_ok = sending_data_to_cache
                 && (state_q == IDLE || state_q == DRAIN)
                 && chk_valid
                 && (chk_tag == sb_addr[31:6]);

  assign fwd = drain_ok && (sb_addr[31:2] == address[31:2]);

  assign miss = (state_q == IDLE) && !cache_hit
             && ((is_load && !hit_storeBuffer) || is_store);

  assign data_read = (reset && state_q == IDLE && is_load && cache_hit)
                   ? (fwd ? sb_data : rd_word) : '0;

  assign stall                = reset && stall_c;
  assign cache_ready_to_catch = reset && ready_c;

  dcache_array u_array (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .chk_idx   (sb_addr[5:4]),
    .chk_valid (chk_valid),
    .chk_tag   (chk_tag),
    .ww_en     (drain_ok),
    .ww_idx    (sb_addr[5:4]),
    .ww_off    (sb_addr[3:2]),
    .ww_data   (sb_data),
    .lw_en     (lw_en),
    .lw_idx    (miss_q[5:4]),
    .lw_tag    (miss_q[31:6]),
    .lw_line   (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    miss_d    = miss_q;
    stall_c   = 1'b0;
    ready_c   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lw_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_c = !is_load && !is_store;
        if (miss) begin
          stall_c = 1'b1;
          state_d = DRAIN;
          dwell_d = 1'b0;
          miss_d  = {address[31:4], 4'b0};
        end
      end
      DRAIN: begin
        ready_c = 1'b1;
        stall_c = 1'b1;
        dwell_d = 1'b1;
        // Empty store buffer only after the minimum dwell.
        if (dwell_q && !sending_data_to_cache) begin
          state_d = (rd_valid && rd_dirty) ? WB : FILL;
        end
      end
      WB: begin
        stall_c   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, miss_q[5:4], 4'b0};
        mem_wdata = rd_line;
        if (mem_ready) state_d = FILL;
      end
      FILL: begin
        stall_c  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = miss_q;
        if (mem_ready) begin
          lw_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dwell_q <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      miss_q  <= miss_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed + randomized bench for dcache_ctrl against a
// line-level cache model and a word-addressed memory model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_load, is_store, hit_sb;
  logic [31:0]  address;
  logic         cache_hit;
  logic [31:0]  data_read;
  logic         stall, cache_ready_to_catch;
  logic         sending;
  logic [63:0]  data_to_cache;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [4];
  bit          m_dirty [4];
  logic [25:0] m_tag   [4];
  logic [31:0] m_data  [4][4];
  logic [31:0] mem_m   [logic [31:0]];

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .is_load               (is_load),
    .is_store              (is_store),
    .address               (address),
    .hit_storeBuffer       (hit_sb),
    .cache_hit             (cache_hit),
    .data_read             (data_read),
    .stall                 (stall),
    .cache_ready_to_catch  (cache_ready_to_catch),
    .sending_data_to_cache (sending),
    .data_to_cache         (data_to_cache),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_ready             (mem_ready),
    .mem_rdata             (mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_rd(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [127:0] model_line(input logic [1:0] idx);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = m_data[idx][w];
    return l;
  endfunction

  function automatic void model_drain(input logic [31:0] a,
                                      input logic [31:0] d);
    if (m_valid[a[5:4]] && m_tag[a[5:4]] == a[31:6]) begin
      m_data[a[5:4]][a[3:2]] = d;
      m_dirty[a[5:4]] = 1'b1;
    end
  endfunction

  function automatic void model_wb(input logic [1:0] idx);
    logic [31:0] base;
    base = {m_tag[idx], idx, 4'b0};
    for (int w = 0; w < 4; w++) mem_m[base + 32'(w * 4)] = m_data[idx][w];
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    logic [1:0] idx;
    idx = a[5:4];
    m_valid[idx] = 1'b1;
    m_dirty[idx] = 1'b0;
    m_tag[idx]   = a[31:6];
    for (int w = 0; w < 4; w++)
      m_data[idx][w] = mem_rd({a[31:4], 4'b0} + 32'(w * 4));
  endfunction

  task automatic serve_miss(input logic [31:0] a, input int nd);
    logic [1:0]  idx;
    logic [25:0] vtag;
    logic [31:0] fill_a;
    logic [63:0] q[$];
    logic [63:0] wd;
    logic [1:0]  o;
    bit          vv, exp_wb, saw_wb, saw_fill, done, mem_seen;
    int          nde, drain_cyc, exp_drain;
    idx       = a[5:4];
    vtag      = m_tag[idx];
    vv        = m_valid[idx];
    fill_a    = {a[31:4], 4'b0};
    nde       = vv ? nd : 0;
    exp_wb    = vv && (m_dirty[idx] || nde > 0);
    exp_drain = (nde + 1 < 2) ? 2 : nde + 1;
    for (int i = 0; i < nde; i++) begin
      o = 2'($urandom_range(0, 3));
      q.push_back({vtag, idx, o, 2'b00, 32'($urandom())});
    end
    saw_wb = 0; saw_fill = 0; done = 0; mem_seen = 0; drain_cyc = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (q.size() > 0 && !mem_seen) begin
        wd = q.pop_front();
        sending = 1'b1;
        data_to_cache = wd;
        model_drain(wd[63:32], wd[31:0]);
      end else begin
        sending = 1'b0;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = mem_line(fill_a);
      #1;
      if (!stall) begin
        done = 1;
      end else if (!mem_req) begin
        drain_cyc++;
        chk("drain_ready", cache_ready_to_catch, 1);
      end else begin
        if (!mem_seen) begin
          mem_seen = 1;
          chk("drain_len", drain_cyc, exp_drain);
        end
        if (mem_we) begin
          chk("wb_addr", mem_addr, {vtag, idx, 4'b0});
          chk("wb_data", mem_wdata, model_line(idx));
          if (mem_ready) begin
            saw_wb = 1;
            model_wb(idx);
          end
        end else begin
          chk("fill_addr", mem_addr, fill_a);
          if (mem_ready) begin
            saw_fill = 1;
            model_fill(a);
          end
        end
      end
    end
    chk("miss_done", done, 1);
    chk("wb_seen", saw_wb, exp_wb);
    chk("fill_seen", saw_fill, 1);
  endtask

  task automatic access(input bit ld, input logic [31:0] a,
                        input bit hsb, input int nd);
    logic [1:0] idx;
    logic [1:0] off;
    bit         hit;
    idx = a[5:4];
    off = a[3:2];
    hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
    @(negedge clk);
    is_load = ld; is_store = !ld; address = a; hit_sb = hsb;
    sending = 1'b0; mem_ready = 1'b0;
    #1;
    chk("cache_hit", cache_hit, hit);
    if (hit || (ld && hsb)) begin
      chk("no_stall", stall, 0);
      if (ld && hit) chk("load_data", data_read, m_data[idx][off]);
    end else begin
      chk("miss_stall", stall, 1);
      serve_miss(a, nd);
      chk("post_hit", cache_hit, 1);
      chk("post_stall", stall, 0);
      if (ld) chk("post_data", data_read, m_data[idx][off]);
    end
  endtask

  task automatic drain_w(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    is_load = 0; is_store = 0; hit_sb = 0; mem_ready = 0;
    sending = 1'b1; data_to_cache = {a, d};
    #1;
    chk("ready_idle", cache_ready_to_catch, 1);
    chk("drain_nostall", stall, 0);
    model_drain(a, d);
  endtask

  task automatic fwd_load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    is_load = 1; is_store = 0; hit_sb = 0; mem_ready = 0;
    address = a; sending = 1'b1; data_to_cache = {a, d};
    #1;
    chk("fwd_hit", cache_hit, 1);
    chk("fwd_data", data_read, d);
    model_drain(a, d);
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    bit reached, last_we, acked;
    @(negedge clk);
    is_load = 1; is_store = 0; address = a; hit_sb = 0;
    sending = 0; mem_ready = 0;
    #1;
    chk("rst_miss", stall, 1);
    reached = 0; last_we = 0; acked = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge clk);
      mem_ready = last_we && !acked;
      mem_rdata = mem_line({a[31:4], 4'b0});
      #1;
      if (mem_req && mem_we) begin
        if (mem_ready) begin
          acked = 1;
          model_wb(a[5:4]);
        end
        last_we = 1;
      end else if (mem_req) begin
        reached = 1;
      end
    end
    chk("fill_reached", reached, 1);
    reset = 0; is_load = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ready", cache_ready_to_catch, 0);
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    @(negedge clk);
    reset = 1;
    #1;
    chk("rel_ready", cache_ready_to_catch, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  r;
    int          op;
    reset = 0; is_load = 0; is_store = 0; hit_sb = 0;
    address = 0; sending = 0; data_to_cache = 0;
    mem_ready = 0; mem_rdata = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_req", mem_req, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_ready", cache_ready_to_catch, 0);
    chk("reset_data", data_read, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("idle_ready", cache_ready_to_catch, 1);

    access(1, 32'h0000_0040, 0, 0);
    drain_w(32'h0000_0044, 32'hDEAD_BEEF);
    access(1, 32'h0000_0044, 0, 0);
    fwd_load(32'h0000_0048, 32'h0000_1234);
    access(1, 32'h0000_0048, 0, 0);
    access(1, 32'h0000_0084, 0, 0);
    access(1, 32'h0000_0040, 0, 3);
    access(0, 32'h0000_0040, 0, 0);
    access(1, 32'h0000_00C0, 1, 0);
    reset_mid_fill(32'h0000_0100);
    access(1, 32'h0000_0040, 0, 0);

    for (int n = 0; n < 300; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 4);
      r  = a[5:4];
      if (op >= 3 && m_valid[r]) begin
        drain_w({m_tag[r], r, a[3:2], 2'b00}, $urandom());
      end else begin
        access(op != 1, a, op == 2, $urandom_range(0, 3));
      end
    end

    @(negedge clk);
    is_load = 0; is_store = 0; sending = 0; mem_ready = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
